signal_monitor: RTL and testbench

Safety monitor (conflict monitor) that reads the 2-bit highway and country light codes produced by the signal controller. It checks them every clock for illegal codes, conflicting greens and yellows, illegal sequences, and yellow/clearance timing violations. The first violation is latched as a fault and a flash output is driven for the fail-safe red-flash driver. The block sits between the controller outputs and the lamp drivers, in parallel, and is purely an observer.

---
 rtl/signal_pkg.sv | 30 +++
 rtl/signal_side_tracker.sv | 57 +++++
 rtl/signal_monitor.sv | 128 ++++++++++++
 tb/tb_signal_monitor.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/signal_pkg.sv
// Shared light encoding and fault codes for the signal controller and its
// conflict monitor.
package signal_pkg;

   typedef logic [1:0] light_t;

   localparam light_t RED     = 2'd0;
   localparam light_t YELLOW  = 2'd1;
   localparam light_t GREEN   = 2'd2;
   localparam light_t INVALID = 2'd3;

   // Listed in recording priority: lower value wins when several coincide.
   typedef enum logic [2:0] {
      NONE         = 3'd0,
      BAD_CODE     = 3'd1,
      CONFLICT     = 3'd2,
      BAD_SEQ      = 3'd3,
      SHORT_YELLOW = 3'd4,
      SHORT_CLEAR  = 3'd5,
      STUCK_YELLOW = 3'd6
   } fault_t;

   // Only G->Y, Y->R, R->G (or no change) are legal lamp transitions.
   function automatic logic is_bad_seq(light_t prev, light_t cur);
      return ((prev == GREEN)  && (cur == RED))    ||
             ((prev == YELLOW) && (cur == GREEN))  ||
             ((prev == RED)    && (cur == YELLOW));
   endfunction

endpackage

// File: rtl/signal_side_tracker.sv
// Per-side observer: remembers the previous lamp code and how long the side
// has shown YELLOW, and flags every per-side rule violation for this sample.
module signal_side_tracker
   import signal_pkg::*;
#(
   parameter int MIN_YELLOW = 3,
   parameter int MAX_YELLOW = 8
) (
   input  logic       clock,
   input  logic       clear_n,
   input  logic [1:0] code,
   output logic       bad_code,
   output logic       bad_seq,
   output logic       short_yellow,
   output logic       stuck_yellow,
   output logic       red_to_green,
   output logic       not_red
);

   localparam int DW = $clog2(MAX_YELLOW + 1);
   localparam logic [DW-1:0] DWELL_MAX = DW'(MAX_YELLOW);
   localparam logic [DW-1:0] DWELL_MIN = DW'(MIN_YELLOW);

   light_t          prev_q;
   logic [DW-1:0]   dwell_q;
   logic [DW-1:0]   dwell_d;

   // Yellow dwell: count consecutive YELLOW samples, saturating at MAX_YELLOW.
   always_comb begin
      dwell_d = '0;
      if (code == YELLOW) begin
         if (prev_q != YELLOW)          dwell_d = DW'(1);
         else if (dwell_q == DWELL_MAX) dwell_d = dwell_q;
         else                           dwell_d = dwell_q + 1'b1;
      end
   end

   // Previous code starts as RED so the first RED->GREEN after reset is legal.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         prev_q  <= RED;
         dwell_q <= '0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         prev_q  <= code;
         dwell_q <= dwell_d;
      end
   end

   assign bad_code     = (code == INVALID);
   assign bad_seq      = is_bad_seq(prev_q, code);
   assign short_yellow = (prev_q == YELLOW) && (code == RED)    && (dwell_q <  DWELL_MIN);
   assign stuck_yellow = (prev_q == YELLOW) && (code == YELLOW) && (dwell_q >= DWELL_MAX);
   assign red_to_green = (prev_q == RED)    && (code == GREEN);
   assign not_red      = (code != RED);

endmodule

// File: rtl/signal_monitor.sv
// Conflict monitor: watches both lamp codes every clock, latches the first
// violation and drives a flash signal for the fail-safe red-flash driver.
module signal_monitor
   import signal_pkg::*;
#(
   parameter int MIN_YELLOW = 3,
   parameter int MAX_YELLOW = 8,
   parameter int MIN_CLEAR  = 2,
   parameter int FLASH_HALF = 4
) (
   input  logic       clock,
   input  logic       clear_n,
   input  logic [1:0] hwy,
   input  logic [1:0] cntry,
   input  logic       ack,
   output logic       fault,
   output logic [2:0] fault_code,
   output logic       flash
);

   localparam int AW = $clog2(MIN_CLEAR + 1);
   localparam int FW = $clog2(FLASH_HALF + 1);
   localparam logic [AW-1:0] CLEAR_SAT  = AW'(MIN_CLEAR);
   localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);

   logic h_bad_code, h_bad_seq, h_short_y, h_stuck_y, h_r2g, h_not_red;
   logic c_bad_code, c_bad_seq, c_short_y, c_stuck_y, c_r2g, c_not_red;

   signal_side_tracker #(.MIN_YELLOW(MIN_YELLOW), .MAX_YELLOW(MAX_YELLOW)) u_hwy (
      .clock        (clock),
      .clear_n      (clear_n),
      .code         (hwy),
      .bad_code     (h_bad_code),
      .bad_seq      (h_bad_seq),
      .short_yellow (h_short_y),
      .stuck_yellow (h_stuck_y),
      .red_to_green (h_r2g),
      .not_red      (h_not_red)
   );

   signal_side_tracker #(.MIN_YELLOW(MIN_YELLOW), .MAX_YELLOW(MAX_YELLOW)) u_cntry (
      .clock        (clock),
      .clear_n      (clear_n),
      .code         (cntry),
      .bad_code     (c_bad_code),
      .bad_seq      (c_bad_seq),
      .short_yellow (c_short_y),
      .stuck_yellow (c_stuck_y),
      .red_to_green (c_r2g),
      .not_red      (c_not_red)
   );

   logic            both_red;
   logic [AW-1:0]   allred_q, allred_d;
   fault_t          viol;
   logic            fault_q, fault_d;
   fault_t          code_q, code_d;
   logic            flash_q, flash_d;
   logic [FW-1:0]   fcnt_q, fcnt_d;

   assign both_red = !h_not_red && !c_not_red;

   // All-red clearance counter, saturating at MIN_CLEAR.
   always_comb begin
      allred_d = '0;
      if (both_red) allred_d = (allred_q == CLEAR_SAT) ? allred_q : allred_q + 1'b1;
   end

   // Priority encode: only the most severe violation of this sample is kept.
   always_comb begin
      // NOTE: default first so no path leaves viol unassigned (no latch).
      viol = NONE;
      if (h_bad_code || c_bad_code)                   viol = BAD_CODE;
      else if (h_not_red && c_not_red)                viol = CONFLICT;
      else if (h_bad_seq || c_bad_seq)                viol = BAD_SEQ;
      else if (h_short_y || c_short_y)                viol = SHORT_YELLOW;
      else if ((h_r2g || c_r2g) && (allred_q < CLEAR_SAT)) viol = SHORT_CLEAR;
      else if (h_stuck_y || c_stuck_y)                viol = STUCK_YELLOW;
   end

   // Fault latch and flash generator: first fault sticks until a clean acked all-red.
   always_comb begin
      fault_d = fault_q;
      code_d  = code_q;
      flash_d = flash_q;
      fcnt_d  = fcnt_q;
      if (!fault_q) begin
         if (viol != NONE) begin
            fault_d = 1'b1;
            code_d  = viol;
            flash_d = 1'b1;
            fcnt_d  = '0;
         end
      end else if ((viol == NONE) && ack && both_red) begin
         fault_d = 1'b0;
         code_d  = NONE;
         flash_d = 1'b0;
         fcnt_d  = '0;
      end else if (fcnt_q == FLASH_LAST) begin
         fcnt_d  = '0;
         flash_d = ~flash_q;
      end else begin
         fcnt_d  = fcnt_q + 1'b1;
      end
   end

   // State registers; the clearance counter starts saturated.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         allred_q <= CLEAR_SAT;
         fault_q  <= 1'b0;
         code_q   <= NONE;
         flash_q  <= 1'b0;
         fcnt_q   <= '0;
      end else begin
         allred_q <= allred_d;
         fault_q  <= fault_d;
         code_q   <= code_d;
         flash_q  <= flash_d;
         fcnt_q   <= fcnt_d;
      end
   end

   assign fault      = fault_q;
   assign fault_code = code_q;
   assign flash      = flash_q;

endmodule

// File: tb/tb_signal_monitor.sv
// Self-checking bench for signal_monitor: directed scenarios plus a biased
// random walk, all compared against a behavioural monitor model.
module tb_signal_monitor;

   localparam int MIN_YELLOW = 3;
   localparam int MAX_YELLOW = 8;
   localparam int MIN_CLEAR  = 2;
   localparam int FLASH_HALF = 4;

   localparam int R = 0, Y = 1, G = 2, X = 3;

   logic       clock = 1'b0;
   logic       clear_n = 1'b0;
   logic [1:0] hwy = 2'd0;
   logic [1:0] cntry = 2'd0;
   logic       ack = 1'b0;
   logic       fault;
   logic [2:0] fault_code;
   logic       flash;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state (plain integers).
   int m_ph, m_pc, m_dh, m_dc, m_ar;
   int m_fault, m_code, m_cyc, m_acyc;

   signal_monitor #(
      .MIN_YELLOW (MIN_YELLOW),
      .MAX_YELLOW (MAX_YELLOW),
      .MIN_CLEAR  (MIN_CLEAR),
      .FLASH_HALF (FLASH_HALF)
   ) dut (
      .clock      (clock),
      .clear_n    (clear_n),
      .hwy        (hwy),
      .cntry      (cntry),
      .ack        (ack),
      .fault      (fault),
      .fault_code (fault_code),
      .flash      (flash)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, m_cyc, got, exp);
      end
   endtask

   function automatic bit bad_seq(int p, int c);
      return (p == G && c == R) || (p == Y && c == G) || (p == R && c == Y);
   endfunction

   function automatic int min_i(int a, int b);
      return (a < b) ? a : b;
   endfunction

   // Violation for this sample, from the rule list in priority order.
   function automatic int model_viol(int h, int c);
      if (h == X || c == X)                                           return 1;
      if (h != R && c != R)                                           return 2;
      if (bad_seq(m_ph, h) || bad_seq(m_pc, c))                       return 3;
      if ((m_ph == Y && h == R && m_dh < MIN_YELLOW) ||
          (m_pc == Y && c == R && m_dc < MIN_YELLOW))                 return 4;
      if (((m_ph == R && h == G) || (m_pc == R && c == G)) && m_ar < MIN_CLEAR) return 5;
      if ((m_ph == Y && h == Y && m_dh >= MAX_YELLOW) ||
          (m_pc == Y && c == Y && m_dc >= MAX_YELLOW))                return 6;
      return 0;
   endfunction

   task automatic model_reset();
      m_ph = R; m_pc = R; m_dh = 0; m_dc = 0; m_ar = MIN_CLEAR;
      m_fault = 0; m_code = 0; m_acyc = 0;
   endtask

   task automatic model_edge(input int h, input int c, input bit a);
      int v;
      v = model_viol(h, c);
      m_cyc++;
      if (m_fault == 0) begin
         if (v != 0) begin
            m_fault = 1; m_code = v; m_acyc = m_cyc;
         end
      end else if (v == 0 && a && h == R && c == R) begin
         m_fault = 0; m_code = 0;
      end
      m_dh = (h == Y) ? ((m_ph == Y) ? min_i(m_dh + 1, MAX_YELLOW) : 1) : 0;
      m_dc = (c == Y) ? ((m_pc == Y) ? min_i(m_dc + 1, MAX_YELLOW) : 1) : 0;
      m_ar = (h == R && c == R) ? min_i(m_ar + 1, MIN_CLEAR) : 0;
      m_ph = h; m_pc = c;
   endtask

   function automatic int model_flash();
      if (m_fault == 0) return 0;
      return (((m_cyc - m_acyc) / FLASH_HALF) % 2 == 0) ? 1 : 0;
   endfunction

   task automatic check_outputs(input string where);
      check({where, ".fault"},      32'(fault),      32'(m_fault));
      check({where, ".fault_code"}, 32'(fault_code), 32'(m_code));
      check({where, ".flash"},      32'(flash),      32'(model_flash()));
   endtask

   // One sample: drive at negedge, let the DUT and model see the edge, check.
   task automatic step(input int h, input int c, input bit a, input string where);
      @(negedge clock);
      hwy = 2'(h); cntry = 2'(c); ack = a;
      @(posedge clock);
      model_edge(h, c, a);
      #1;
      check_outputs(where);
   endtask

   task automatic do_reset();
      @(negedge clock);
      clear_n = 1'b0; hwy = 2'd0; cntry = 2'd0; ack = 1'b0;
      model_reset();
      @(negedge clock);
      clear_n = 1'b1;
   endtask

   initial begin
      int h, c, r;
      m_cyc = 0;
      model_reset();
      #2;
      check("reset.fault",      32'(fault),      32'd0);
      check("reset.fault_code", 32'(fault_code), 32'd0);
      check("reset.flash",      32'(flash),      32'd0);
      do_reset();

      // 1: legal full cycle
      for (int i = 0; i < 5; i++) step(G, R, 0, "t1");
      for (int i = 0; i < 3; i++) step(Y, R, 0, "t1");
      for (int i = 0; i < 2; i++) step(R, R, 0, "t1");
      for (int i = 0; i < 4; i++) step(R, G, 0, "t1");
      for (int i = 0; i < 3; i++) step(R, Y, 0, "t1");
      for (int i = 0; i < 2; i++) step(R, R, 0, "t1");
      step(G, R, 0, "t1");
      check("t1.no_fault", 32'(fault), 32'd0);

      // 2: conflicting greens, flash pattern, first code sticks
      do_reset();
      step(G, R, 0, "t2");
      step(G, G, 0, "t2");
      check("t2.code_conflict", 32'(fault_code), 32'd2);
      check("t2.flash_on",      32'(flash),      32'd1);
      for (int i = 0; i < 9; i++) step(G, G, 0, "t2.flash");
      step(Y, R, 0, "t2");
      check("t2.code_held", 32'(fault_code), 32'd2);

      // 3a: yellow too short
      do_reset();
      step(G, R, 0, "t3a");
      step(Y, R, 0, "t3a");
      step(Y, R, 0, "t3a");
      step(R, R, 0, "t3a");
      check("t3a.short_yellow", 32'(fault_code), 32'd4);

      // 3b: yellow held too long
      do_reset();
      step(G, R, 0, "t3b");
      for (int i = 0; i < 8; i++) step(Y, R, 0, "t3b");
      check("t3b.eight_ok", 32'(fault), 32'd0);
      step(Y, R, 0, "t3b");
      check("t3b.stuck_yellow", 32'(fault_code), 32'd6);

      // 4: green straight to red
      do_reset();
      step(G, R, 0, "t4");
      step(R, R, 0, "t4");
      check("t4.bad_seq", 32'(fault_code), 32'd3);

      // 5: short clearance, ignored ack, valid ack
      do_reset();
      step(G, R, 0, "t5");
      for (int i = 0; i < 3; i++) step(Y, R, 0, "t5");
      step(R, R, 0, "t5");
      step(G, R, 0, "t5");
      check("t5.short_clear", 32'(fault_code), 32'd5);
      step(G, R, 1, "t5.ack_green");
      check("t5.ack_ignored", 32'(fault), 32'd1);
      for (int i = 0; i < 3; i++) step(Y, R, 0, "t5");
      step(R, R, 1, "t5.ack_clear");
      check("t5.cleared_fault", 32'(fault),      32'd0);
      check("t5.cleared_code",  32'(fault_code), 32'd0);
      check("t5.cleared_flash", 32'(flash),      32'd0);

      // 6: bad code outranks conflict; async reset mid-fault
      do_reset();
      step(X, G, 0, "t6");
      check("t6.bad_code", 32'(fault_code), 32'd1);
      step(X, G, 0, "t6");
      step(R, G, 0, "t6");
      @(posedge clock);
      #2;
      clear_n = 1'b0;
      #1;
      check("t6.rst_fault", 32'(fault),      32'd0);
      check("t6.rst_code",  32'(fault_code), 32'd0);
      check("t6.rst_flash", 32'(flash),      32'd0);
      model_reset();
      hwy = 2'd0; cntry = 2'd0; ack = 1'b0;
      @(negedge clock);
      clear_n = 1'b1;
      step(G, R, 0, "t6.resume");
      check("t6.resume_ok", 32'(fault), 32'd0);

      // Random walk: mostly holds and plausible changes, occasional garbage.
      do_reset();
      h = R; c = R;
      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 55) begin
            // hold
         end else if (r < 72) begin
            h = R; c = R;
         end else if (r < 95) begin
            if ($urandom_range(0, 1) == 0) begin
               h = int'($urandom_range(0, 2)); c = R;
            end else begin
               c = int'($urandom_range(0, 2)); h = R;
            end
         end else begin
            h = int'($urandom_range(0, 3)); c = int'($urandom_range(0, 3));
         end
         step(h, c, ($urandom_range(0, 3) == 0), "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
